// File: rtl/packet_demux.sv
// Header-framed stream demultiplexer feeding per-channel item FIFOs.
// Define PACKET_DEMUX_ERROR_COUNT_EN to enable the saturating error counter.
module packet_demux #(
    parameter int CHANNEL_COUNT        = 4,
    parameter int WORD_SIZE            = 8,
    parameter int CHANNEL_WORDS        = 2,
    parameter int SEGMENT_SIZE         = 4,
    parameter int FIFO_DEPTH           = 4,
    parameter int HEADER_COUNT_SHIFT   = 0,
    parameter int HEADER_CHANNEL_SHIFT = 4,
    parameter int HEADER_END_SHIFT     = 6,
    parameter int HEADER_MARK_BIT      = 7
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [WORD_SIZE-1:0]                        in_data,
    output logic [CHANNEL_COUNT-1:0]                    out_nempty,
    input  logic [CHANNEL_COUNT-1:0]                    out_pop,
    output logic [CHANNEL_COUNT*CHANNEL_WORDS*WORD_SIZE-1:0] out_data,
    output logic [CHANNEL_COUNT-1:0]                    out_end,
    output logic [15:0]                                 err_count
);
    localparam int ITEM_W = CHANNEL_WORDS * WORD_SIZE;
    localparam int CNT_W  = $clog2(SEGMENT_SIZE) + 1;
    localparam int CHF_W  = HEADER_END_SHIFT - HEADER_CHANNEL_SHIFT;
    localparam int CH_W   = CHANNEL_COUNT > 1 ? $clog2(CHANNEL_COUNT) : 1;
    localparam int IDX_W  = CHANNEL_WORDS > 1 ? $clog2(CHANNEL_WORDS) : 1;
    localparam int PTR_W  = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W  = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {HEADER, PAYLOAD} state_t;

    state_t               state, state_d;
    logic [IDX_W-1:0]     word_index;
    logic [CH_W-1:0]      chan;
    logic [CNT_W-1:0]     remaining;
    logic                 end_flag;
    logic [ITEM_W-1:0]    assembly, assembly_next;
    logic [CHANNEL_COUNT-1:0] full;

    logic                 hdr_mark, hdr_end, hdr_ok;
    logic [CNT_W-1:0]     hdr_cnt;
    logic [CHF_W-1:0]     hdr_ch;
    logic [(1<<CHF_W)-1:0] ch_mask;
    logic                 accept, last_word, item_end;
    logic                 hdr_take, hdr_err, item_wr;
    logic                 unused_bits;

    assign hdr_mark = in_data[HEADER_MARK_BIT];
    assign hdr_end  = in_data[HEADER_END_SHIFT];
    assign hdr_cnt  = in_data[HEADER_COUNT_SHIFT +: CNT_W];
    assign hdr_ch   = in_data[HEADER_CHANNEL_SHIFT +: CHF_W];

    // Channel legality as a lookup so non-power-of-two counts work.
    for (genvar c = 0; c < (1 << CHF_W); c++) begin : g_mask
        assign ch_mask[c] = (c < CHANNEL_COUNT);
    end

    assign hdr_ok = hdr_mark && (hdr_cnt != '0)
                 && (hdr_cnt <= CNT_W'(SEGMENT_SIZE))
                 && ch_mask[hdr_ch];

    assign last_word = (word_index == IDX_W'(CHANNEL_WORDS - 1));
    assign item_end  = end_flag && (remaining == CNT_W'(1));
    assign in_ready  = !((state == PAYLOAD) && last_word && full[chan]);
    assign accept    = in_valid && in_ready;
    assign assembly_next = ITEM_W'({assembly, in_data});

    always_ff @(posedge clk) begin
        if (rst) state <= HEADER;
        else     state <= state_d;
    end

    always_comb begin
        state_d  = state;
        hdr_take = 1'b0;
        hdr_err  = 1'b0;
        item_wr  = 1'b0;
        unique case (state)
            HEADER: begin
                if (accept) begin
                    if (hdr_ok) begin
                        hdr_take = 1'b1;
                        state_d  = PAYLOAD;
                    end else begin
                        hdr_err = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (accept && last_word) begin
                    item_wr = 1'b1;
                    if (remaining == CNT_W'(1)) state_d = HEADER;
                end
            end
            default: state_d = HEADER;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_index <= '0;
            chan       <= '0;
            remaining  <= '0;
            end_flag   <= 1'b0;
            assembly   <= '0;
        end else if (hdr_take) begin
            chan       <= CH_W'(hdr_ch);
            remaining  <= hdr_cnt;
            end_flag   <= hdr_end;
            word_index <= '0;
        end else if (state == PAYLOAD && accept) begin
            assembly <= assembly_next;
            if (last_word) begin
                word_index <= '0;
                remaining  <= remaining - CNT_W'(1);
            end else begin
                word_index <= word_index + IDX_W'(1);
            end
        end
    end

    for (genvar g = 0; g < CHANNEL_COUNT; g++) begin : g_fifo
        logic [ITEM_W:0]    mem [FIFO_DEPTH];
        logic [PTR_W-1:0]   wp, rp;
        logic [OCC_W-1:0]   occ;
        logic               wr, pop;

        assign wr  = item_wr && (chan == CH_W'(g));
        assign pop = out_pop[g] && (occ != '0);

        always_ff @(posedge clk) begin
            if (rst) begin
                wp  <= '0;
                rp  <= '0;
                occ <= '0;
            end else begin
                if (wr)  wp <= wp + PTR_W'(1);
                if (pop) rp <= rp + PTR_W'(1);
                unique case ({wr, pop})
                    2'b10:   occ <= occ + OCC_W'(1);
                    2'b01:   occ <= occ - OCC_W'(1);
                    default: occ <= occ;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (wr) mem[wp] <= {item_end, assembly_next};
        end

        assign full[g]       = (occ == OCC_W'(FIFO_DEPTH));
        assign out_nempty[g] = (occ != '0);
        assign out_data[g*ITEM_W +: ITEM_W] =
            out_nempty[g] ? mem[rp][ITEM_W-1:0] : '0;
        assign out_end[g] = out_nempty[g] & mem[rp][ITEM_W];
    end

`ifdef PACKET_DEMUX_ERROR_COUNT_EN
    logic [15:0] err_q;
    always_ff @(posedge clk) begin
        if (rst)
            err_q <= '0;
        else if (hdr_err && err_q != 16'hFFFF)
            err_q <= err_q + 16'd1;
    end
    assign err_count = err_q;
`else
    assign err_count = '0;
`endif

    // Header bits outside the decoded fields are intentionally ignored.
    assign unused_bits = ^{in_data, hdr_err};
endmodule

// File: tb/tb_packet_demux.sv
// Directed and scoreboard-driven bench for packet_demux.
module tb_packet_demux;
`ifdef PACKET_DEMUX_ERROR_COUNT_EN
    localparam int ERR_ON = 1;
`else
    localparam int ERR_ON = 0;
`endif

    logic        clk = 0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [3:0]  out_nempty;
    logic [3:0]  out_pop;
    logic [63:0] out_data;
    logic [3:0]  out_end;
    logic [15:0] err_count;

    int tests = 0;
    int fails = 0;
    int exp_err = 0;

    packet_demux dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_nempty(out_nempty), .out_pop(out_pop),
        .out_data(out_data), .out_end(out_end),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  hdr;
        logic [7:0]  w0;
        logic [7:0]  w1;
        int          ch;
        logic [15:0] d;
        logic        e;
    } vec_t;

    typedef struct packed {
        logic [15:0] d;
        logic        e;
    } item_t;

    vec_t  vecs [8];
    item_t sb [4][$];
    logic [7:0] words [$];

    function automatic logic [15:0] slice(input int g);
        return out_data[g*16 +: 16];
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] w);
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: word %h never accepted", w);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic pop(input int g);
        out_pop[g] = 1'b1;
        @(posedge clk); #1;
        out_pop = '0;
    endtask

    initial begin
        logic [7:0] a, b, hdr;
        logic [15:0] d;
        int cnt, ch, wi, cyc;
        logic e, adv;

        vecs[0] = '{8'hC1, 8'hAA, 8'hBB, 0, 16'hAABB, 1'b1};
        vecs[1] = '{8'h91, 8'h12, 8'h34, 1, 16'h1234, 1'b0};
        vecs[2] = '{8'hE1, 8'h56, 8'h78, 2, 16'h5678, 1'b1};
        vecs[3] = '{8'hB1, 8'h9A, 8'hBC, 3, 16'h9ABC, 1'b0};
        vecs[4] = '{8'h41, 8'h00, 8'h00, -1, 16'h0, 1'b0};
        vecs[5] = '{8'h85, 8'h00, 8'h00, -1, 16'h0, 1'b0};
        vecs[6] = '{8'h87, 8'h00, 8'h00, -1, 16'h0, 1'b0};
        vecs[7] = '{8'h80, 8'h00, 8'h00, -1, 16'h0, 1'b0};

        rst = 1; in_valid = 0; in_data = 0; out_pop = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_nempty", out_nempty, 4'h0);
        check("rst_data", out_data, 64'h0);
        check("rst_end", out_end, 4'h0);
        check("rst_err", err_count, 16'h0);
        rst = 0;
        check("rst_ready", in_ready, 1'b1);

        for (int i = 0; i < 8; i++) begin
            check($sformatf("v%0d_ready", i), in_ready, 1'b1);
            send(vecs[i].hdr);
            if (vecs[i].ch >= 0) begin
                send(vecs[i].w0);
                send(vecs[i].w1);
                check($sformatf("v%0d_nempty", i), out_nempty,
                      64'(4'b1 << vecs[i].ch));
                check($sformatf("v%0d_data", i), slice(vecs[i].ch),
                      vecs[i].d);
                check($sformatf("v%0d_end", i), out_end[vecs[i].ch],
                      vecs[i].e);
                pop(vecs[i].ch);
            end else begin
                exp_err += ERR_ON;
            end
            check($sformatf("v%0d_empty", i), out_nempty, 4'h0);
            check($sformatf("v%0d_err", i), err_count, 16'(exp_err));
        end

        send(8'hD2); send(8'hAA); send(8'hBB);
        send(8'hCC); send(8'hDD);
        check("seg_nempty", out_nempty, 4'b0010);
        check("seg_item0", slice(1), 16'hAABB);
        check("seg_end0", out_end[1], 1'b0);
        pop(1);
        check("seg_item1", slice(1), 16'hCCDD);
        check("seg_end1", out_end[1], 1'b1);
        pop(1);
        check("seg_drained", out_nempty, 4'h0);
        check("seg_data0", out_data, 64'h0);

        send(8'h11); send(8'h80);
        exp_err += 2 * ERR_ON;
        send(8'h81); send(8'h12); send(8'h34);
        check("err_count", err_count, 16'(exp_err));
        check("err_nempty", out_nempty, 4'b0001);
        check("err_item", slice(0), 16'h1234);
        check("err_end", out_end[0], 1'b0);
        pop(0);

        for (int k = 0; k < 4; k++) begin
            a = 8'(8'h30 + k);
            b = 8'(8'h40 + k);
            send(8'hB1); send(a); send(b);
        end
        check("bp_nempty", out_nempty, 4'b1000);
        send(8'hB1); send(8'h34);
        in_valid = 1'b1;
        in_data  = 8'h44;
        check("bp_ready0", in_ready, 1'b0);
        @(posedge clk); #1;
        check("bp_hold", in_ready, 1'b0);
        out_pop = 4'b1000;
        check("bp_head", slice(3), 16'h3040);
        check("bp_no_comb", in_ready, 1'b0);
        @(posedge clk); #1;
        out_pop = '0;
        check("bp_ready1", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k < 5; k++) begin
            a = 8'(8'h30 + k);
            b = 8'(8'h40 + k);
            check($sformatf("bp_item%0d", k), slice(3), {a, b});
            check($sformatf("bp_end%0d", k), out_end[3], 1'b0);
            pop(3);
        end
        check("bp_drained", out_nempty, 4'h0);

        send(8'hE1); send(8'h11); send(8'h22);
        send(8'h94); send(8'h01);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        exp_err = 0;
        check("mid_ready", in_ready, 1'b1);
        check("mid_nempty", out_nempty, 4'h0);
        check("mid_err", err_count, 16'h0);
        send(8'hC1); send(8'h56); send(8'h78);
        check("mid_only0", out_nempty, 4'b0001);
        check("mid_item", slice(0), 16'h5678);
        check("mid_end", out_end[0], 1'b1);
        pop(0);

        for (int s = 0; s < 160; s++) begin
            ch  = $urandom_range(0, 3);
            cnt = $urandom_range(1, 4);
            e   = 1'($urandom_range(0, 1));
            hdr = {1'b1, e, 2'(ch), 1'b0, 3'(cnt)};
            words.push_back(hdr);
            for (int j = 0; j < cnt; j++) begin
                d = 16'($urandom);
                words.push_back(d[15:8]);
                words.push_back(d[7:0]);
                sb[ch].push_back({d, e && (j == cnt - 1)});
            end
        end

        wi = 0;
        cyc = 0;
        while ((wi < words.size() || sb[0].size() > 0 || sb[1].size() > 0
                || sb[2].size() > 0 || sb[3].size() > 0) && cyc < 20000) begin
            in_valid = (wi < words.size());
            in_data  = in_valid ? words[wi] : 8'h00;
            for (int g = 0; g < 4; g++) begin
                out_pop[g] = ($urandom_range(0, 2) == 0);
                if (out_pop[g] && out_nempty[g]) begin
                    if (sb[g].size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL rand_extra_ch%0d: got %h expected none",
                                 g, slice(g));
                    end else begin
                        check($sformatf("rand_ch%0d", g),
                              {slice(g), out_end[g]}, sb[g][0]);
                        void'(sb[g].pop_front());
                    end
                end
            end
            adv = in_valid && in_ready;
            @(posedge clk); #1;
            if (adv) wi++;
            cyc++;
        end
        in_valid = 0;
        out_pop  = 0;
        check("rand_words_done", 64'(wi), 64'(words.size()));
        for (int g = 0; g < 4; g++)
            check($sformatf("rand_left_ch%0d", g), 64'(sb[g].size()), 64'h0);
        check("rand_nempty", out_nempty, 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
